// File: rtl/feeder_pkg.sv
// Shared defaults and width helpers for the operand feeder slice.
// The helpers let each module size its counters from its own parameters.
package feeder_pkg;

    localparam int FEEDER_DATA_W          = 8;
    localparam int FEEDER_DEBOUNCE_CYCLES = 50000;
    localparam int FEEDER_FIFO_DEPTH      = 4;

    // Counter width for the debounce counter, which only needs to reach cycles-1.
    function automatic int debounce_cnt_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    function automatic int fifo_count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/operand_feeder_if.sv
// Valid/ready operand stream from the feeder to the accumulator.
// The master side is the feeder; the slave side is the consumer.
interface operand_feeder_if
    import feeder_pkg::*;
#(
    parameter int DATA_W = FEEDER_DATA_W
) ();

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/key_debounce.sv
// Synchronises and debounces the raw active-low pushbutton.
// Emits a one-cycle press strobe per debounced 1->0 transition.
module key_debounce
    import feeder_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = FEEDER_DEBOUNCE_CYCLES,
    localparam int CNT_W           = debounce_cnt_w(DEBOUNCE_CYCLES)
) (
    input  logic clock,
    input  logic reset,
    input  logic i_key_n,
    output logic o_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_key_s1;
    logic             r_key_s;
    logic             r_key_db;
    logic             r_key_db_d1;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_settled;

    // Two-flop synchroniser; reset parks it at the released level.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_key_s1 <= 1'b1;
            r_key_s  <= 1'b1;
        end else begin
            r_key_s1 <= i_key_n;
            r_key_s  <= r_key_s1;
        end
    end

    assign w_differ  = (r_key_s != r_key_db);
    assign w_settled = w_differ && (r_cnt == CNT_LAST);

    // Any return to the debounced level restarts the stability count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_key_db    <= 1'b1;
            r_key_db_d1 <= 1'b1;
        end else begin
            r_key_db_d1 <= r_key_db;
            if (w_settled) begin
                r_key_db <= r_key_s;
                r_cnt    <= '0;
            end else if (w_differ) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_key_db_d1 & ~r_key_db;

endmodule

// File: rtl/operand_feeder.sv
// Turns a bouncy pushbutton plus switch operand into queued single-shot
// operand transfers on a show-ahead valid/ready stream.
module operand_feeder
    import feeder_pkg::*;
#(
    parameter  int DATA_W          = FEEDER_DATA_W,
    parameter  int DEBOUNCE_CYCLES = FEEDER_DEBOUNCE_CYCLES,
    parameter  int FIFO_DEPTH      = FEEDER_FIFO_DEPTH,
    localparam int COUNT_W         = fifo_count_w(FIFO_DEPTH),
    localparam int PTR_W           = fifo_ptr_w(FIFO_DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               key_n,
    input  logic [DATA_W-1:0]  sw_data,
    operand_feeder_if.master   out_if,
    output logic [COUNT_W-1:0] fifo_count,
    output logic               drop_flag
);

    localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0]  r_sw_s1;
    logic [DATA_W-1:0]  r_sw_s;
    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [COUNT_W-1:0] r_count;
    logic               r_drop;
    logic               w_press;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clock   (clock),
        .reset   (reset),
        .i_key_n (key_n),
        .o_press (w_press)
    );

    // The operand bus is synchronised alongside the key so the captured value
    // has settled by the time the press strobe arrives.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sw_s1 <= '0;
            r_sw_s  <= '0;
        end else begin
            r_sw_s1 <= sw_data;
            r_sw_s  <= r_sw_s1;
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == COUNT_FULL);
    assign w_pop   = out_if.out_ready && !w_empty;
    assign w_push  = w_press && (!w_full || w_pop);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_sw_s;
        end
    end

    // A full queue frees its head slot when the consumer pops in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_W'(1);
                2'b01:   r_count <= r_count - COUNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_press && !w_push) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign out_if.out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign out_if.out_valid = !w_empty;
    assign fifo_count       = r_count;
    assign drop_flag        = r_drop;

endmodule

// File: tb/tb_operand_feeder.sv
// Bench for operand_feeder: directed scenarios plus randomized key/ready
// traffic, all compared against a sliding-window debounce and queue model.
module tb_operand_feeder;

    localparam int DW    = 8;
    localparam int DB    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          key_n;
    logic [DW-1:0] sw_data;
    logic [CW-1:0] fifo_count;
    logic          drop_flag;

    int n_total = 0;
    int n_pass  = 0;

    operand_feeder_if #(.DATA_W(DW)) bus ();

    operand_feeder #(
        .DATA_W          (DW),
        .DEBOUNCE_CYCLES (DB),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_n      (key_n),
        .sw_data    (sw_data),
        .out_if     (bus),
        .fifo_count (fifo_count),
        .drop_flag  (drop_flag)
    );

    always #5 clock = ~clock;

    // Reference model: the debounced level flips once the last DB synchronised
    // samples all disagree with it; the queue is a plain SV queue.
    bit            m_ok = 1'b0;
    bit            m_ks1;
    bit            m_db;
    bit            m_db_d1;
    bit            m_drop;
    bit            ks_hist[$];
    logic [DW-1:0] m_sw1;
    logic [DW-1:0] m_sw2;
    logic [DW-1:0] mq[$];

    always @(posedge clock) begin : model
        bit m_press;
        bit m_pop;
        bit all_diff;
        if (reset === 1'b0) begin
            m_ks1   = 1'b1;
            m_db    = 1'b1;
            m_db_d1 = 1'b1;
            m_drop  = 1'b0;
            m_sw1   = '0;
            m_sw2   = '0;
            ks_hist = {};
            for (int i = 0; i < DB; i++) ks_hist.push_back(1'b1);
            mq      = {};
            m_ok    = 1'b1;
        end else if (m_ok) begin
            m_press = m_db_d1 && !m_db;
            m_pop   = (mq.size() != 0) && (bus.out_ready === 1'b1);
            if (m_pop) void'(mq.pop_front());
            if (m_press) begin
                if (mq.size() < DEPTH) mq.push_back(m_sw2);
                else m_drop = 1'b1;
            end
            all_diff = 1'b1;
            foreach (ks_hist[i]) if (ks_hist[i] == m_db) all_diff = 1'b0;
            m_db_d1 = m_db;
            if (all_diff) m_db = !m_db;
            ks_hist.push_back(m_ks1);
            void'(ks_hist.pop_front());
            m_ks1 = key_n;
            m_sw2 = m_sw1;
            m_sw1 = sw_data;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (m_ok) begin
            checkOutput("cyc_count", 32'(fifo_count), 32'(mq.size()));
            checkOutput("cyc_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
            checkOutput("cyc_drop", 32'(drop_flag), 32'(m_drop));
            if (mq.size() != 0) checkOutput("cyc_data", 32'(bus.out_data), 32'(mq[0]));
        end
    end

    task automatic applyStimulus(input logic k, input logic [DW-1:0] sw, input logic rdy, input int n);
        key_n         = k;
        sw_data       = sw;
        bus.out_ready = rdy;
        repeat (n) @(negedge clock);
    endtask

    task automatic doPress(input logic [DW-1:0] v);
        applyStimulus(1'b0, v, 1'b0, DB + 3);
        applyStimulus(1'b1, v, 1'b0, DB + 3);
    endtask

    task automatic drainExpect(input string name, input logic [DW-1:0] vals[$]);
        bus.out_ready = 1'b1;
        foreach (vals[i]) begin
            checkOutput(name, 32'(bus.out_data), 32'(vals[i]));
            @(negedge clock);
        end
        bus.out_ready = 1'b0;
        checkOutput({name, "_empty"}, 32'(bus.out_valid), 32'd0);
        checkOutput({name, "_count"}, 32'(fifo_count), 32'd0);
    endtask

    initial begin
        reset         = 1'b0;
        key_n         = 1'b1;
        sw_data       = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_count", 32'(fifo_count), 32'd0);
        checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_data", 32'(bus.out_data), 32'd0);
        checkOutput("reset_drop", 32'(drop_flag), 32'd0);
        reset = 1'b1;
        applyStimulus(1'b1, 8'h00, 1'b0, 3);

        // Clean press: entry visible after edge DB+3 = 7.
        applyStimulus(1'b0, 8'h25, 1'b0, 6);
        checkOutput("press_e6_valid", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b0, 8'h25, 1'b0, 1);
        checkOutput("press_e7_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("press_e7_data", 32'(bus.out_data), 32'h25);
        checkOutput("press_e7_count", 32'(fifo_count), 32'd1);
        applyStimulus(1'b1, 8'h25, 1'b0, 15);
        checkOutput("release_count", 32'(fifo_count), 32'd1);
        applyStimulus(1'b1, 8'h00, 1'b1, 1);
        checkOutput("pop_count", 32'(fifo_count), 32'd0);

        // Bounce shorter than the debounce window.
        repeat (5) begin
            applyStimulus(1'b0, 8'h77, 1'b0, 3);
            applyStimulus(1'b1, 8'h77, 1'b0, 1);
        end
        applyStimulus(1'b1, 8'h77, 1'b0, 10);
        checkOutput("bounce_count", 32'(fifo_count), 32'd0);
        checkOutput("bounce_valid", 32'(bus.out_valid), 32'd0);

        // Fill and overflow.
        for (int v = 1; v <= 5; v++) doPress(8'(v));
        checkOutput("ovf_count", 32'(fifo_count), 32'd4);
        checkOutput("ovf_drop", 32'(drop_flag), 32'd1);
        drainExpect("ovf_drain", '{8'h01, 8'h02, 8'h03, 8'h04});

        // Mid-operation reset with the key held low through it.
        doPress(8'h11);
        doPress(8'h12);
        checkOutput("mid_pre_count", 32'(fifo_count), 32'd2);
        key_n   = 1'b0;
        sw_data = 8'h33;
        reset   = 1'b0;
        @(negedge clock);
        checkOutput("mid_rst_count", 32'(fifo_count), 32'd0);
        checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_rst_drop", 32'(drop_flag), 32'd0);
        reset = 1'b1;
        applyStimulus(1'b0, 8'h33, 1'b0, 6);
        checkOutput("mid_e6_valid", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b0, 8'h33, 1'b0, 1);
        checkOutput("mid_e7_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("mid_e7_data", 32'(bus.out_data), 32'h33);
        applyStimulus(1'b0, 8'h33, 1'b0, 20);
        checkOutput("mid_once_count", 32'(fifo_count), 32'd1);
        applyStimulus(1'b1, 8'h33, 1'b0, DB + 3);
        drainExpect("mid_drain", '{8'h33});

        // Push coincides with a pop on a full queue.
        for (int v = 1; v <= 4; v++) doPress(8'(v));
        applyStimulus(1'b0, 8'h09, 1'b0, 6);
        applyStimulus(1'b0, 8'h09, 1'b1, 1);
        bus.out_ready = 1'b0;
        checkOutput("full_pp_count", 32'(fifo_count), 32'd4);
        checkOutput("full_pp_drop", 32'(drop_flag), 32'd0);
        applyStimulus(1'b1, 8'h09, 1'b0, DB + 3);
        drainExpect("full_pp_drain", '{8'h02, 8'h03, 8'h04, 8'h09});

        // Stalled head stays stable while the switches move.
        doPress(8'h5A);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1);
            checkOutput("stall_data", 32'(bus.out_data), 32'h5A);
            checkOutput("stall_count", 32'(fifo_count), 32'd1);
        end
        drainExpect("stall_drain", '{8'h5A});

        // Randomized key levels, ready and occasional reset.
        for (int it = 0; it < 220; it++) begin
            logic k;
            int   hold;
            k    = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 12);
            for (int j = 0; j < hold; j++) begin
                reset = ($urandom_range(0, 150) == 0) ? 1'b0 : 1'b1;
                applyStimulus(k, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 2) == 0), 1);
            end
        end
        reset = 1'b1;
        applyStimulus(1'b1, 8'h00, 1'b1, 20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/operand_feeder.md
Name: operand_feeder

Overview:
- Upstream stage of the 8-bit accumulator.
- Converts a raw, bouncy, active-low pushbutton plus slide-switch operand into clean, single-shot operand transfers.
- Queues captured operands in a small FIFO and presents them on a valid/ready interface.
- The accumulator consumes one operand per accepted transfer, so it runs on the system clock instead of a button clock.

Parameters:
- DATA_W, 8: operand width in bits.
- DEBOUNCE_CYCLES, 50000: consecutive stable samples needed to accept a level change (1 ms at 50 MHz). Must be ≥2.
- FIFO_DEPTH, 4: operand queue entries. Must be a power of 2 and ≥2.

Ports:
- clock, in, 1: system clock; all logic is on its rising edge.
- reset, in, 1: synchronous, active-low reset.
- key_n, in, 1: raw pushbutton; 0 = pressed; asynchronous and bouncy.
- sw_data, in, DATA_W: raw switch operand; asynchronous.
- out_data, out, DATA_W: FIFO head operand.
- out_valid, out, 1: FIFO non-empty.
- out_ready, in, 1: consumer accepts out_data this cycle.
- fifo_count, out, $clog2(FIFO_DEPTH+1): number of queued entries.
- drop_flag, out, 1: sticky; a press occurred while the FIFO was full.

Behaviour:
- Reset (reset==0 at a clock edge):
  - Sync flops and debounced level are set to 1 (released); counter is 0.
  - FIFO pointers are 0; fifo_count=0, out_valid=0, out_data=0, drop_flag=0.
  - Reset mid-operation discards queued operands and any debounce in progress.
- Synchronisers: key_n and sw_data each pass through two flops, giving key_s and sw_s.
- Debounce:
  - The counter increments each cycle key_s != key_db and clears to 0 whenever they are equal.
  - When the counter == DEBOUNCE_CYCLES-1 and the levels still differ, key_db <= key_s and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Press event:
  - press = key_db_d1 & ~key_db, where key_db_d1 is key_db delayed one cycle.
  - press is high for exactly one cycle per debounced 1->0 transition.
  - A release (0->1) produces no event.
- Latency: count the first edge sampling key_n low as edge 1, with key_n held low.
  - key_s is low after edge 2.
  - key_db is low after edge D+2 (D = DEBOUNCE_CYCLES).
  - press is high during the cycle after edge D+2.
  - The FIFO writes sw_s at edge D+3.
  - out_valid is high after edge D+3.
- FIFO:
  - Show-ahead: out_data is always the oldest entry whenever out_valid=1.
  - Pop occurs when out_valid & out_ready. Push occurs when press & (not full, or pop in the same cycle).
  - Push and pop in the same cycle: count is unchanged; allowed when full and when non-empty.
  - Push when empty: the entry becomes visible the next cycle; there is no same-cycle bypass.
  - Pop when empty: ignored; out_ready may be held high freely.
  - Push when full without a pop: the operand is discarded and drop_flag <= 1. drop_flag holds until reset.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_count is exact: 0..FIFO_DEPTH.
- Handshake: out_data and out_valid change only at clock edges. A held un-accepted entry stays stable.
- Key held low across reset release: exactly one press, with out_valid high after the (D+3)-th edge following reset release.

Decomposition:
- Package feeder_pkg holds:
  - DATA_W default;
  - the counter-width constant $clog2(DEBOUNCE_CYCLES);
  - the count-width constant $clog2(FIFO_DEPTH+1).
- One sub-module, key_debounce: sync flops, counter, key_db and the press strobe.
- The sw_data synchroniser and the FIFO stay in operand_feeder.

Test Plan:
- Clean press: DEBOUNCE_CYCLES=4, sw_data=8'h25, out_ready=0, key_n low from edge 1 -> out_valid rises after edge 7, out_data=8'h25, fifo_count=1.
- Bounce: key_n toggles low 3 cycles / high 1 cycle, repeated 5 times, then high -> no push, fifo_count stays 0, out_valid=0. Release after a valid press -> no additional entry.
- Fill and overflow: out_ready=0, five presses with sw_data 01,02,03,04,05 -> fifo_count=4, drop_flag=1. Then out_ready=1 -> out_data sequence 01,02,03,04, one per cycle, then out_valid=0, fifo_count=0.
- Full with simultaneous push/pop: queue holds 01..04; press with sw_data=09 timed so the push coincides with out_ready=1 -> 01 popped, fifo_count stays 4, drop_flag stays 0. Drain order is 02,03,04,09.
- Mid-operation reset: queue holds 2 entries, reset=0 for one edge -> next cycle fifo_count=0, out_valid=0, drop_flag=0. With key_n held low, exactly one new entry appears 7 edges after reset release.
- Stall stability: out_valid=1, out_ready=0 for 10 cycles while sw_data changes -> out_data constant, fifo_count unchanged.
